// File: rtl/universal_shift_register.sv
// Universal shift register: WIDTH-bit register with parallel load and a
// multi-cycle burst engine that performs amt single-bit shifts/rotates,
// one per clock, then pulses done for one cycle.
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  localparam logic [AMT_W-1:0] CNT_ZERO = '0;
  localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [1:0]       op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;

  // Next-state logic: load/start are only honoured in IDLE; the burst uses
  // the op latched at start so mid-burst input changes have no effect.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          q_d = din;
        end else if (start) begin
          op_d = op;
          if (amt != CNT_ZERO) begin
            cnt_d   = amt;
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        unique case (op_q)
          OP_SLL: begin
            q_d    = {q_q[WIDTH-2:0], sin};
            sout_d = q_q[WIDTH-1];
          end
          OP_SRL: begin
            q_d    = {sin, q_q[WIDTH-1:1]};
            sout_d = q_q[0];
          end
          OP_ROL: begin
            q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            sout_d = q_q[WIDTH-1];
          end
          OP_SRA: begin
            q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            sout_d = q_q[0];
          end
          default: begin
            q_d    = q_q;
            sout_d = sout_q;
          end
        endcase
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any burst immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      sout_q  <= 1'b0;
      op_q    <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_universal_shift_register.sv
// Testbench for universal_shift_register: directed cases plus random bursts,
// with expected burst results queued at issue time and checked by a monitor
// whenever the DUT pulses done.
module tb_universal_shift_register;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          load;
  logic [W-1:0]  din;
  logic          start;
  logic [1:0]    op;
  logic [AW-1:0] amt;
  logic          sin;
  logic [W-1:0]  q;
  logic          sout;
  logic          busy;
  logic          done;

  universal_shift_register #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .din   (din),
    .start (start),
    .op    (op),
    .amt   (amt),
    .sin   (sin),
    .q     (q),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    int expQ;
    int expSout;
    int expBusy;
  } exp_t;

  exp_t expQueue[$];
  int   checks    = 0;
  int   passed    = 0;
  int   busyRun   = 0;
  int   doneCount = 0;
  int   mq        = 0;
  int   msout     = 0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: closed-form result of an n-bit burst.
  function automatic void burstModel(input int qi, input int si, input int o,
                                     input int n, input int fill,
                                     output int qo, output int so);
    int mask;
    int r;
    int sx;
    mask = (1 << W) - 1;
    qo = qi;
    so = si;
    if (n == 0) return;
    case (o)
      0: begin
        if (n >= W) qo = fill ? mask : 0;
        else qo = ((qi << n) | (fill ? ((1 << n) - 1) : 0)) & mask;
        so = (n <= W) ? ((qi >> (W - n)) & 1) : fill;
      end
      1: begin
        if (n >= W) qo = fill ? mask : 0;
        else qo = (qi >> n) | (fill ? (mask & ~(mask >> n)) : 0);
        so = (n <= W) ? ((qi >> (n - 1)) & 1) : fill;
      end
      2: begin
        r  = n % W;
        qo = ((qi << r) | (qi >> (W - r))) & mask;
        so = qo & 1;
      end
      default: begin
        sx = ((qi >> (W - 1)) & 1) ? (qi | ~mask) : qi;
        qo = (sx >>> n) & mask;
        so = (n <= W) ? ((qi >> (n - 1)) & 1) : ((qi >> (W - 1)) & 1);
      end
    endcase
  endfunction

  // Monitor: tracks busy length and scores each done pulse against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busyRun = 0;
    end else begin
      if (busy) busyRun++;
      if (done) begin
        doneCount++;
        if (expQueue.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = expQueue.pop_front();
          checkOutput("burst_q", int'(q), e.expQ);
          checkOutput("burst_sout", int'(sout), e.expSout);
          checkOutput("burst_busy_cycles", busyRun, e.expBusy);
        end
        busyRun = 0;
      end
    end
  end

  task automatic doLoad(input int value);
    load  = 1'b1;
    din   = W'(value);
    start = 1'b0;
    @(posedge clk); #1;
    load = 1'b0;
    mq   = value;
    checkOutput("load_q", int'(q), value);
  endtask

  // Issue a burst, push its expected result, scribble on ignored inputs while
  // it runs, and return in the IDLE cycle right after done.
  task automatic applyStimulus(input int o, input int n, input int fill,
                               input bit disturb);
    exp_t e;
    int   nq;
    int   ns;
    bit   seen;
    burstModel(mq, msout, o, n, fill, nq, ns);
    e.expQ = nq; e.expSout = ns; e.expBusy = n;
    expQueue.push_back(e);
    mq = nq; msout = ns;
    op = 2'(o); amt = AW'(n); sin = fill ? 1'b1 : 1'b0;
    start = 1'b1; load = 1'b0;
    @(posedge clk); #1;
    seen = 1'b0;
    for (int i = 0; i < n + 6; i++) begin
      if (disturb) begin
        start = 1'b1; load = 1'b1; din = 8'hFF;
        op = 2'($urandom_range(0, 3)); amt = AW'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) seen = 1'b1;
      @(posedge clk); #1;
      if (seen) break;
    end
    start = 1'b0; load = 1'b0;
    if (!seen) checkOutput("done_timeout", 0, 1);
  endtask

  initial begin
    int dc;
    rst = 1'b1; load = 1'b0; din = '0; start = 1'b0;
    op = 2'b00; amt = '0; sin = 1'b0;
    #2;
    checkOutput("reset_q", int'(q), 0);
    checkOutput("reset_sout", int'(sout), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Parallel load, then load+start together: load wins, start dropped.
    doLoad(8'hA5);
    load = 1'b1; start = 1'b1; din = 8'h3C; op = 2'b10; amt = 4'd3;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
    mq = 8'h3C;
    checkOutput("load_start_q", int'(q), 8'h3C);
    checkOutput("load_start_busy", int'(busy), 0);
    @(posedge clk); #1;
    checkOutput("load_start_busy_later", int'(busy), 0);
    checkOutput("load_start_done_later", int'(done), 0);

    // Rotate A5 left by 3 -> 2D, sout 1.
    doLoad(8'hA5);
    applyStimulus(2, 3, 0, 1'b0);
    checkOutput("rol_q_direct", int'(q), 8'h2D);

    // Arithmetic shift with ignored load/start during the burst.
    doLoad(8'h90);
    applyStimulus(3, 2, 0, 1'b1);
    checkOutput("sra_q_direct", int'(q), 8'hE4);

    // Zero-length burst and overshift.
    doLoad(8'h5A);
    applyStimulus(0, 0, 0, 1'b0);
    checkOutput("amt0_q", int'(q), 8'h5A);
    doLoad(8'h00);
    applyStimulus(1, 9, 1, 1'b0);
    checkOutput("srl9_q", int'(q), 8'hFF);
    checkOutput("srl9_sout", int'(sout), 1);

    // Back-to-back bursts.
    doLoad(8'h81);
    dc = doneCount;
    applyStimulus(2, 8, 0, 1'b0);
    applyStimulus(0, 1, 0, 1'b0);
    checkOutput("b2b_q", int'(q), 8'h02);
    checkOutput("b2b_sout", int'(sout), 1);
    checkOutput("b2b_done_pulses", doneCount - dc, 2);

    // Random bursts with occasional loads.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) doLoad(int'($urandom_range(0, 255)));
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    // Reset in the 2nd cycle of an amt=5 burst aborts with no done.
    doLoad(8'hC3);
    op = 2'b10; amt = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_q", int'(q), 0);
    checkOutput("abort_sout", int'(sout), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    dc = doneCount;
    @(posedge clk); #1;
    rst = 1'b0;
    mq = 0; msout = 0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("abort_no_done", doneCount - dc, 0);
    checkOutput("abort_queue_empty", expQueue.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit register with parallel load and a multi-cycle burst shift/rotate engine.
- A start pulse performs amt single-bit shifts, one per clock, then flags done.
- Used as a serial/parallel converter and barrel-shift substitute in lab datapaths.

Parameters:
- WIDTH, 8, register width in bits (must be at least 2).
- AMT_W, 4, width of the shift-count input; amt may exceed WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  parallel-load request; honoured only in IDLE.
- din  input  WIDTH  parallel load data.
- start  input  1  burst-shift request; honoured only in IDLE.
- op  input  2  burst operation: 00 SLL, 01 SRL, 10 ROL, 11 SRA.
- amt  input  AMT_W  number of single-bit shifts in the burst.
- sin  input  1  serial fill bit for SLL/SRL; sampled on every shift edge.
- q  output  WIDTH  register contents.
- sout  output  1  last bit shifted/rotated out; registered.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse in DONE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. clk and rst as named above.
- Reset values: q=0, sout=0, busy=0, done=0, state=IDLE, internal op and count registers cleared. Reset asserted mid-burst aborts the burst immediately; no done pulse follows.
- States: IDLE, SHIFT, DONE. busy=(state==SHIFT) and done=(state==DONE), both decoded from the state register.
- IDLE:
  - load=1: q<=din at the next edge; sout unchanged; stay in IDLE.
  - else start=1: latch op and amt. If amt!=0, go to SHIFT with cnt=amt. If amt==0, go to DONE with q unchanged.
  - load and start together: load wins; start is dropped and not queued.
- SHIFT, every edge:
  - Apply one shift per op:
    - SLL: q<={q[W-2:0],sin}, sout<=q[W-1].
    - SRL: q<={sin,q[W-1:1]}, sout<=q[0].
    - ROL: q<={q[W-2:0],q[W-1]}, sout<=q[W-1].
    - SRA: q<={q[W-1],q[W-1:1]}, sout<=q[0].
  - cnt<=cnt-1. If cnt==1 before the edge, go to DONE.
- DONE: lasts exactly one cycle, then returns to IDLE. q is final and stable while done=1.
- Inputs ignored outside IDLE: load, start, op and amt are ignored in SHIFT and DONE. Changing op or amt mid-burst has no effect.
- Latency: start sampled at edge k; shifts occur at edges k+1..k+amt; done is high between edges k+amt and k+amt+1. For amt=0, done is high between edges k and k+1.
- Back-to-back: start may be sampled in the IDLE cycle immediately after DONE.
- Overshift: amt>WIDTH is legal. Shifts are simply repeated; ROL wraps modulo WIDTH naturally.

Test Plan:
- Reset: rst=1 in the 2nd cycle of an amt=5 burst -> q=0, busy=0, done=0 immediately (before the next clk edge); no done pulse afterwards.
- Parallel load: load=1, din=8'hA5 in IDLE -> q=8'hA5 after one edge. Then load=1 and start=1 together with din=8'h3C -> q=8'h3C, busy stays 0.
- Rotate: q=8'hA5, op=ROL, amt=3 -> busy high 3 cycles, then done pulse for 1 cycle, q=8'h2D, sout=1.
- Arithmetic shift: q=8'h90, op=SRA, amt=2 -> q=8'hE4, sout=0. During the burst, start=1 and load=1 with din=8'hFF -> ignored, q still 8'hE4.
- Zero/overshift:
  - amt=0, op=SLL on q=8'h5A -> done on the next cycle, busy never high, q=8'h5A.
  - q=8'h00, op=SRL, sin=1, amt=9 -> q=8'hFF, sout=1, done 9 cycles after busy rises.
- Back-to-back: start issued in the cycle after done (SLL, amt=1, sin=0, q=8'h81) -> q=8'h02, sout=1, second done pulse observed.
